// File: rtl/demux_buf_if.sv
// Handshake bundle for demux_buf: one producer stream in, two consumer streams out.
// master = producer/consumers side, slave = the demux itself.
interface demux_buf_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;

    modport master (
        output in_data, in_sel, in_valid, a_ready, b_ready,
        input  in_ready, a_data, a_valid, b_data, b_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, a_ready, b_ready,
        output in_ready, a_data, a_valid, b_data, b_valid
    );
endinterface

// File: rtl/demux_buf.sv
// Buffered 1:2 demux, a DEPTH-entry FIFO per output; accepted word is visible one cycle later.
// in_ready tracks only the selected FIFO's full flag (no pass-through on full).
// Optional per-output push counters a_cnt/b_cnt under `define DEMUX_CNT_EN.
module demux_buf #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    demux_buf_if.slave bus
`ifdef DEMUX_CNT_EN
    ,
    output logic [7:0] a_cnt,
    output logic [7:0] b_cnt
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem    [2][DEPTH];
    logic [PW-1:0]    r_wr_ptr [2];
    logic [PW-1:0]    r_rd_ptr [2];
    logic [CW-1:0]    r_cnt    [2];

    logic [1:0] w_full;
    logic [1:0] w_empty;
    logic [1:0] w_ready;
    logic [1:0] w_push;
    logic [1:0] w_pop;
    logic       w_accept;

    assign w_full[0]  = (r_cnt[0] == CW'(DEPTH));
    assign w_full[1]  = (r_cnt[1] == CW'(DEPTH));
    assign w_empty[0] = (r_cnt[0] == '0);
    assign w_empty[1] = (r_cnt[1] == '0);
    assign w_ready[0] = bus.a_ready;
    assign w_ready[1] = bus.b_ready;

    // Readiness depends only on the selector and registered occupancy.
    assign bus.in_ready = bus.in_sel ? !w_full[1] : !w_full[0];
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_push[0]    = w_accept && !bus.in_sel;
    assign w_push[1]    = w_accept &&  bus.in_sel;
    assign w_pop        = ~w_empty & w_ready;

    assign bus.a_valid = !w_empty[0];
    assign bus.b_valid = !w_empty[1];
    assign bus.a_data  = r_mem[0][r_rd_ptr[0]];
    assign bus.b_data  = r_mem[1][r_rd_ptr[1]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                r_wr_ptr[s] <= '0;
                r_rd_ptr[s] <= '0;
                r_cnt[s]    <= '0;
                for (int e = 0; e < DEPTH; e++) begin
                    r_mem[s][e] <= '0;
                end
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (w_push[s]) begin
                    r_mem[s][r_wr_ptr[s]] <= bus.in_data;
                    r_wr_ptr[s]           <= r_wr_ptr[s] + PW'(1);
                end
                if (w_pop[s]) begin
                    r_rd_ptr[s] <= r_rd_ptr[s] + PW'(1);
                end
                case ({w_push[s], w_pop[s]})
                    2'b10:   r_cnt[s] <= r_cnt[s] + CW'(1);
                    2'b01:   r_cnt[s] <= r_cnt[s] - CW'(1);
                    default: r_cnt[s] <= r_cnt[s];
                endcase
            end
        end
    end

`ifdef DEMUX_CNT_EN
    logic [7:0] r_push_cnt [2];

    // Free-running 8-bit tallies of accepted words, wrapping naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_push_cnt[0] <= '0;
            r_push_cnt[1] <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (w_push[s]) begin
                    r_push_cnt[s] <= r_push_cnt[s] + 8'd1;
                end
            end
        end
    end

    assign a_cnt = r_push_cnt[0];
    assign b_cnt = r_push_cnt[1];
`else
    // Counter ports are absent in this build.
`endif
endmodule

// File: tb/tb_demux_buf.sv
// Scoreboard bench for demux_buf: per-output queues model the FIFOs, monitor checks outputs.
module tb_demux_buf;
    localparam int WIDTH = 4;
    localparam int DEPTH = 2;

    logic clk;
    logic rst_n;

    demux_buf_if #(.WIDTH(WIDTH)) bus ();

`ifdef DEMUX_CNT_EN
    logic [7:0] a_cnt;
    logic [7:0] b_cnt;
`endif

    demux_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef DEMUX_CNT_EN
        ,
        .a_cnt (a_cnt),
        .b_cnt (b_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] qb[$];
    logic [7:0]       m_a_cnt;
    logic [7:0]       m_b_cnt;
    int               n_checks;
    int               n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive, compare in_ready at mid-cycle, record acceptance at the edge.
    task automatic cycle(input bit v, input bit s, input logic [WIDTH-1:0] d,
                         input bit ar, input bit br);
        bit acc;
        bus.in_valid = v;
        bus.in_sel   = s;
        bus.in_data  = d;
        bus.a_ready  = ar;
        bus.b_ready  = br;
        @(negedge clk);
        chk("in_ready", {31'd0, bus.in_ready},
            {31'd0, ((s ? qb.size() : qa.size()) < DEPTH)});
        acc = v && bus.in_ready;
        @(posedge clk);
        if (acc) begin
            if (s) begin qb.push_back(d); m_b_cnt++; end
            else   begin qa.push_back(d); m_a_cnt++; end
        end
        #1;
    endtask

    task automatic idle(input int n, input bit ar, input bit br);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, ar, br);
    endtask

    // Async reset asserted mid-cycle with traffic present; released off the clock edge.
    task automatic do_reset();
        bus.in_valid = 1'b1;
        bus.in_sel   = 1'b0;
        bus.in_data  = 4'hF;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_a_valid", {31'd0, bus.a_valid}, 32'd0);
        chk("rst_b_valid", {31'd0, bus.b_valid}, 32'd0);
        chk("rst_a_data", {28'd0, bus.a_data}, 32'd0);
        chk("rst_b_data", {28'd0, bus.b_data}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
`ifdef DEMUX_CNT_EN
        chk("rst_a_cnt", {24'd0, a_cnt}, 32'd0);
        chk("rst_b_cnt", {24'd0, b_cnt}, 32'd0);
`endif
        qa.delete();
        qb.delete();
        m_a_cnt = '0;
        m_b_cnt = '0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares outputs at mid-cycle, retires heads at the following edge.
    initial begin
        bit pa, pb;
        forever begin
            @(negedge clk);
            pa = 1'b0;
            pb = 1'b0;
            if (rst_n) begin
                chk("a_valid", {31'd0, bus.a_valid}, {31'd0, qa.size() != 0});
                chk("b_valid", {31'd0, bus.b_valid}, {31'd0, qb.size() != 0});
                chk("a_data_known", {31'd0, $isunknown(bus.a_data)}, 32'd0);
                chk("b_data_known", {31'd0, $isunknown(bus.b_data)}, 32'd0);
                if (bus.a_valid && bus.a_ready && qa.size() > 0) begin
                    chk("a_data", {28'd0, bus.a_data}, {28'd0, qa[0]});
                    pa = 1'b1;
                end
                if (bus.b_valid && bus.b_ready && qb.size() > 0) begin
                    chk("b_data", {28'd0, bus.b_data}, {28'd0, qb[0]});
                    pb = 1'b1;
                end
`ifdef DEMUX_CNT_EN
                chk("a_cnt", {24'd0, a_cnt}, {24'd0, m_a_cnt});
                chk("b_cnt", {24'd0, b_cnt}, {24'd0, m_b_cnt});
`endif
            end
            @(posedge clk);
            if (pa && rst_n && qa.size() > 0) void'(qa.pop_front());
            if (pb && rst_n && qb.size() > 0) void'(qb.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_a_cnt  = '0;
        m_b_cnt  = '0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sel   = 1'b0;
        bus.in_data  = '0;
        bus.a_ready  = 1'b0;
        bus.b_ready  = 1'b0;
        #12;
        chk("init_a_valid", {31'd0, bus.a_valid}, 32'd0);
        chk("init_b_valid", {31'd0, bus.b_valid}, 32'd0);
        chk("init_a_data", {28'd0, bus.a_data}, 32'd0);
        chk("init_b_data", {28'd0, bus.b_data}, 32'd0);
        chk("init_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3, 1'b1, 1'b1);

        // Routing
        cycle(1'b1, 1'b0, 4'h3, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 4'hC, 1'b1, 1'b1);
        idle(3, 1'b1, 1'b1);

        // Back-pressure isolation: B stalls, A keeps flowing
        cycle(1'b1, 1'b1, 4'h1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 4'h2, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 4'h7, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 4'h5, 1'b1, 1'b0);
        idle(2, 1'b1, 1'b0);

        // Full B with simultaneous pop: first attempt refused, retry accepted
        cycle(1'b1, 1'b1, 4'h9, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 4'h9, 1'b1, 1'b1);
        idle(4, 1'b1, 1'b1);

        // Wrap-around through A with push and pop every cycle
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 4'(i), 1'b1, 1'b1);
        idle(3, 1'b1, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end

        // Async reset in the middle of buffered traffic
        cycle(1'b1, 1'b0, 4'hA, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 4'hB, 1'b0, 1'b0);
        do_reset();
        idle(3, 1'b1, 1'b1);

`ifdef DEMUX_CNT_EN
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 4'(i), 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 4'(i), 1'b1, 1'b1);
        idle(2, 1'b1, 1'b1);
        chk("cnt_a_5", {24'd0, a_cnt}, 32'd5);
        chk("cnt_b_3", {24'd0, b_cnt}, 32'd3);
        do_reset();
        for (int i = 0; i < 256; i++) cycle(1'b1, 1'b0, 4'(i), 1'b1, 1'b1);
        idle(2, 1'b1, 1'b1);
        chk("cnt_a_wrap", {24'd0, a_cnt}, 32'd0);
        cycle(1'b1, 1'b0, 4'h1, 1'b0, 1'b0);
        do_reset();
        idle(2, 1'b1, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
